// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver: active-low glyph
// table, blank pattern and the blink phase type.
package seg7_pkg;

    // Segment order is bit0=a .. bit6=g, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10,  // 9
        7'h08,  // A
        7'h03,  // b
        7'h46,  // C
        7'h21,  // d
        7'h06,  // E
        7'h0E   // F
    };

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous data commit.
// Define SEG7_BLINK_EN to add per-digit blinking driven by blink_mask.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic [3:0]              sel_nibble;
    logic                    sel_dp;
    logic                    sel_en;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [6:0]              glyph_seg;
    logic                    blink_blank;
    logic                    blank;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (wrap) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
        end else if (load) begin
            shadow_data <= data;
            shadow_dp   <= dp_in;
        end
    end

    // A load landing on the wrap edge bypasses the shadow so it shows this frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_data <= '0;
            disp_dp   <= '0;
        end else if (wrap) begin
            disp_data <= load ? data  : shadow_data;
            disp_dp   <= load ? dp_in : shadow_dp;
        end
    end

    always_comb begin
        sel_nibble = '0;
        sel_dp     = 1'b0;
        sel_en     = 1'b0;
        an_onehot  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_nibble   = disp_data[4*i +: 4];
                sel_dp       = disp_dp[i];
                sel_en       = digit_en[i];
                an_onehot[i] = 1'b0;
            end
        end
    end

    seg7_glyph u_glyph (
        .nibble (sel_nibble),
        .seg    (glyph_seg)
    );

`ifdef SEG7_BLINK_EN
    localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);

    logic [BCNT_W-1:0] blink_cnt;
    logic [BCNT_W-1:0] blink_cnt_next;
    blink_phase_t      blink_phase;
    blink_phase_t      blink_phase_next;
    logic              sel_blink;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= BLINK_ON;
        end else begin
            blink_cnt   <= blink_cnt_next;
            blink_phase <= blink_phase_next;
        end
    end

    // Frames are counted at the scan wrap; the phase flips every BLINK_DIV frames.
    always_comb begin
        blink_cnt_next   = blink_cnt;
        blink_phase_next = blink_phase;
        if (wrap) begin
            if (blink_cnt == BCNT_LAST) begin
                blink_cnt_next   = '0;
                blink_phase_next = (blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                blink_cnt_next = blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sel_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_blink = blink_mask[i];
            end
        end
    end

    assign blink_blank = (blink_phase == BLINK_OFF) && sel_blink;
`else
    logic unused_blink_mask;

    assign unused_blink_mask = ^blink_mask;
    assign blink_blank       = 1'b0;
`endif

    assign blank = !sel_en || blink_blank;

    // A blanked digit still occupies its scan slot; only the drive is suppressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (blank) begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= an_onehot;
                seg <= glyph_seg;
                dp  <= ~sel_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed + random bench for seg7_scan_driver; the reference model derives
// digit slot, frame boundaries and blink phase from the elapsed edge count.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BD    = 2;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   data;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en;
    logic          load;
    logic [3:0]    blink_mask;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    int tests = 0;
    int fails = 0;

    // Model state: edges since reset release, shadow and committed display.
    int          m;
    logic [15:0] sh_data;
    logic [3:0]  sh_dp;
    logic [15:0] dsp_data;
    logic [3:0]  dsp_dp;

    logic [6:0] ref_glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .blink_mask (blink_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at t=%0t m=%0d observed=%h expected=%h", tag, $time, m, obs, exp);
        end
    endtask

    function automatic logic blink_off(input int edges);
`ifdef SEG7_BLINK_EN
        return ((edges / FRAME) / BD) % 2 == 1;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: predict the outputs after the coming edge, advance the model, compare.
    task automatic step();
        int         k;
        int         mn;
        logic       blank;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic       exp_fd;
        k       = (m / RD) % ND;
        blank   = !digit_en[k] || (blink_mask[k] && blink_off(m));
        exp_an  = 4'hF;
        if (!blank) exp_an[k] = 1'b0;
        exp_seg = blank ? 7'h7F : ref_glyph[dsp_data[4*k +: 4]];
        exp_dp  = blank ? 1'b1 : !dsp_dp[k];
        mn      = m + 1;
        exp_fd  = (mn % FRAME) == 0;
        if (exp_fd) begin
            dsp_data = load ? data  : sh_data;
            dsp_dp   = load ? dp_in : sh_dp;
        end
        if (load) begin
            sh_data = data;
            sh_dp   = dp_in;
        end
        @(posedge clk);
        #1;
        check("an", {12'h0, an}, {12'h0, exp_an});
        check("seg", {9'h0, seg}, {9'h0, exp_seg});
        check("dp", {15'h0, dp}, {15'h0, exp_dp});
        check("frame_done", {15'h0, frame_done}, {15'h0, exp_fd});
        m = mn;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_seg", {9'h0, seg}, 16'h007F);
        check("rst_dp", {15'h0, dp}, 16'h0001);
        check("rst_fd", {15'h0, frame_done}, 16'h0000);
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        m        = 0;
        sh_data  = '0;
        sh_dp    = '0;
        dsp_data = '0;
        dsp_dp   = '0;
    endtask

    initial begin
        reset      = 1'b1;
        data       = '0;
        dp_in      = '0;
        digit_en   = 4'hF;
        load       = 1'b0;
        blink_mask = '0;
        m          = 0;
        sh_data    = '0;
        sh_dp      = '0;
        dsp_data   = '0;
        dsp_dp     = '0;

        do_reset();

        // Load 1234 once; it appears only after the first wrap.
        data  = 16'h1234;
        dp_in = 4'b0010;
        load  = 1'b1;
        step();
        load  = 1'b0;
        run(2 * FRAME + 5);

        // Mid-frame load of ABCD must wait for the frame boundary.
        data  = 16'hABCD;
        dp_in = 4'b0000;
        load  = 1'b1;
        step();
        load  = 1'b0;
        run(2 * FRAME);

        // Digits 1 and 3 disabled; their slots stay blank.
        digit_en = 4'b0101;
        run(2 * FRAME);
        digit_en = 4'hF;

        // Load coinciding with the wrap edge commits in that same frame.
        data  = 16'h0008;
        dp_in = 4'b1001;
        while (m % FRAME != FRAME - 1) step();
        load  = 1'b1;
        step();
        load  = 1'b0;
        run(FRAME + 3);

        // Blink on digit 0 across several frames.
        blink_mask = 4'b0001;
        run(5 * FRAME);
        blink_mask = 4'b0000;

        // Reset mid-scan discards a pending shadow value.
        data  = 16'h5678;
        dp_in = 4'b1111;
        load  = 1'b1;
        step();
        load  = 1'b0;
        run(3);
        do_reset();
        run(2 * FRAME + 2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            data       = 16'($urandom);
            dp_in      = 4'($urandom_range(0, 15));
            digit_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            blink_mask = 4'($urandom_range(0, 15));
            load       = ($urandom_range(0, 9) == 0);
            step();
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of digits scanned (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is driven (legal >=2).
REQ-003 SHALL have parameter BLINK_DIV, default 250, frames per blink half-period (legal >=1).
REQ-004 SHALL have port clk  input  1  sole clock, all flops on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) feeds digit i.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
REQ-008 SHALL have port digit_en  input  NUM_DIGITS  per-digit enable; 0 blanks that digit.
REQ-009 SHALL have port load  input  1  capture data/dp_in into the shadow register on this edge.
REQ-010 SHALL have port blink_mask  input  NUM_DIGITS  per-digit blink request.
REQ-011 SHALL have port seg  output  7  segment drive, active-low, bit0=a .. bit6=g.
REQ-012 SHALL have port dp  output  1  decimal point drive, active-low.
REQ-013 SHALL have port an  output  NUM_DIGITS  digit anode select, active-low, one-hot-low or all-high.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-015 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; its terminal count is the digit tick.
REQ-016 On digit tick the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-017 On the wrap edge frame_done SHALL be 1 for exactly one cycle, else 0.
REQ-018 load=1 SHALL copy data and dp_in into the shadow register on that edge; load=0 holds it.
REQ-019 On the wrap edge the display register SHALL take the shadow value; with load also 1 on that edge, the new data SHALL be committed (no tearing mid-frame).
REQ-020 seg, dp, an SHALL be registered: one cycle after index changes to i, an[i]=0, other an bits=1.
REQ-021 seg SHALL encode nibble i: 0-9 as digits, A,b,C,d,E,F glyphs (0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E).
REQ-022 dp SHALL equal ~dp bit i of the display register.
REQ-023 digit_en[i]=0 while digit i is selected SHALL give an all ones, seg=7'h7F, dp=1; the scan slot is still consumed.
REQ-024 NUM_DIGITS=1 SHALL wrap every digit tick; frame_done pulses each tick.

Reset
REQ-025 reset=1 SHALL immediately force an all ones, seg=7'h7F, dp=1, frame_done=0.
REQ-026 reset SHALL clear prescaler, index, shadow, display register and blink state to 0.
REQ-027 After reset release, first edge SHALL drive digit 0 (an[0]=0) with seg=7'h40 if digit_en[0]=1.
REQ-028 reset asserted mid-frame SHALL discard the pending shadow value; no commit occurs.

Configuration
REQ-029 Macro SEG7_BLINK_EN defined SHALL enable a frame counter 0..BLINK_DIV-1 toggling a blink phase at wrap; during off-phase digits with blink_mask=1 are blanked as in REQ-023.
REQ-030 Without SEG7_BLINK_EN, blink_mask SHALL be ignored, no blink counter synthesised, port retained.

Structure
REQ-031 Package seg7_pkg SHALL hold the 16-entry active-low glyph table constant and blank constant 7'h7F.
REQ-032 Sub-module seg7_glyph (combinational nibble -> seg using seg7_pkg) SHALL be instantiated once on the selected nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2)
REQ-033 Reset, data=16'h1234 load once, all enabled -> after first wrap an cycles 1110,1101,1011,0111 every 4 clk with seg 4=7'h19,3=7'h30,2=7'h24,1=7'h79 on matching digit.
REQ-034 load data=16'hABCD mid-frame -> displayed digits unchanged until frame_done, then next frame shows d,C,b,A.
REQ-035 digit_en=4'b0101 -> slots for digits 1 and 3 show an=1111, seg=7'h7F; frame length stays 16 clk.
REQ-036 load coinciding with wrap edge, data=16'h0008 -> that frame commits new value, digit 0 seg=7'h00.
REQ-037 SEG7_BLINK_EN, blink_mask=4'b0001 -> digit 0 shown 2 frames, blank 2 frames; other digits always shown; without macro digit 0 never blanks.
REQ-038 reset asserted mid-scan -> an=1111, seg=7'h7F same cycle; after release display shows 0 until next load+wrap.
